bloco_pipe: RTL and testbench

- Parametrised successor to the register-bank + ALU + flag-register datapath.
- Generic word width and register count; valid/ready instruction input; 2-stage pipeline (read/issue, execute/writeback) with result bypass; registered result output; sticky Z/C/S/O flags.
- Sits between the instruction sequencer and the register-visible datapath.

---
 rtl/bloco_pkg.sv | 50 +++++
 rtl/bloco_alu.sv | 66 ++++++
 rtl/bloco_pipe.sv | 172 +++++++++++++++++
 tb/tb_bloco_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bloco_pkg.sv
// Shared definitions for the bloco_pipe datapath: opcodes, flag bit
// positions and opcode classification helpers.
// Optional feature macro: BLOCO_MULT_EN (enables the iterative MUL op).
package bloco_pkg;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_AND = 5'd2,
        OP_OR  = 5'd3,
        OP_XOR = 5'd4,
        OP_NOT = 5'd5,
        OP_SHL = 5'd6,
        OP_SHR = 5'd7,
        OP_MOV = 5'd8,
        OP_CMP = 5'd9,
        OP_LDI = 5'd10,
        OP_MUL = 5'd11
    } op_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_O = 0;

    // True when the opcode writes its result into the register file.
    function automatic logic op_writes(op_e o);
        case (o)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_SHL, OP_SHR, OP_MOV, OP_LDI: return 1'b1;
`ifdef BLOCO_MULT_EN
            OP_MUL: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // True when the opcode updates the sticky flag register.
    function automatic logic op_sets_flags(op_e o);
        case (o)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_SHL, OP_SHR, OP_MOV, OP_CMP: return 1'b1;
`ifdef BLOCO_MULT_EN
            OP_MUL: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bloco_alu.sv
// Combinational ALU for bloco_pipe: produces the result and the next
// value of the {Z,C,S,O} flags for every single-cycle opcode.
// Opcodes it does not implement return 0 and leave the flags untouched.
module bloco_alu
    import bloco_pkg::*;
#(
    parameter int W = 16
) (
    input  op_e          op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] imm_i,
    input  logic [3:0]   flags_i,
    output logic [W-1:0] result_o,
    output logic [3:0]   flags_o
);

    logic [W:0] sum;
    logic [W:0] diff;
    logic       carry;
    logic       ovf;

    // Compute result, carry/borrow and overflow, then fold them into flags.
    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        diff     = {1'b0, a_i} - {1'b0, b_i};
        result_o = '0;
        flags_o  = flags_i;
        carry    = 1'b0;
        ovf      = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = sum[W-1:0];
                carry    = sum[W];
                ovf      = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
            end
            OP_SUB, OP_CMP: begin
                result_o = diff[W-1:0];
                carry    = diff[W];
                ovf      = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_NOT: result_o = ~a_i;
            OP_SHL: begin
                result_o = {a_i[W-2:0], 1'b0};
                carry    = a_i[W-1];
            end
            OP_SHR: begin
                result_o = {1'b0, a_i[W-1:1]};
                carry    = a_i[0];
            end
            OP_MOV: result_o = b_i;
            OP_LDI: result_o = imm_i;
            default: result_o = '0;
        endcase
        if (op_sets_flags(op_i)) begin
            flags_o[FLAG_Z] = (result_o == '0);
            flags_o[FLAG_S] = result_o[W-1];
            flags_o[FLAG_C] = carry;
            flags_o[FLAG_O] = ovf;
        end
    end

endmodule

// File: rtl/bloco_pipe.sv
// bloco_pipe: register bank + ALU + sticky flags as a 2-stage pipeline
// (read/issue, execute/writeback) with result bypass from EX.
// Optional feature macro: BLOCO_MULT_EN (iterative shift-add MUL in EX).
module bloco_pipe
    import bloco_pkg::*;
#(
    parameter int BITS_PALAVRA  = 16,
    parameter int END_REGISTROS = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               op,
    input  logic [END_REGISTROS-1:0] sel_dest,
    input  logic [END_REGISTROS-1:0] sel_a,
    input  logic [END_REGISTROS-1:0] sel_b,
    input  logic [BITS_PALAVRA-1:0]  imm,
    input  logic                     clr_flags,
    output logic                     out_valid,
    output logic [BITS_PALAVRA-1:0]  out_result,
    output logic [END_REGISTROS-1:0] out_dest,
    output logic [3:0]               flags,
    input  logic [END_REGISTROS-1:0] dbg_sel,
    output logic [BITS_PALAVRA-1:0]  dbg_data
);

    localparam int W    = BITS_PALAVRA;
    localparam int NREG = 2 ** END_REGISTROS;

    logic [W-1:0]               regFile_q [NREG];
    logic                       exValid_q;
    op_e                        exOp_q;
    logic [W-1:0]               exA_q, exB_q, exImm_q;
    logic [END_REGISTROS-1:0]   exDest_q;
    logic [3:0]                 flags_q;
    logic                       outValid_q;
    logic [W-1:0]               outResult_q;
    logic [END_REGISTROS-1:0]   outDest_q;

    logic [W-1:0]               aluResult, exResult, opA, opB;
    logic [3:0]                 aluFlags, exFlags;
    logic                       retire, accept, exWrites;

    bloco_alu #(.W(W)) u_alu (
        .op_i    (exOp_q),
        .a_i     (exA_q),
        .b_i     (exB_q),
        .imm_i   (exImm_q),
        .flags_i (flags_q),
        .result_o(aluResult),
        .flags_o (aluFlags)
    );

`ifdef BLOCO_MULT_EN
    localparam int CW = $clog2(W);

    logic [2*W-1:0] mulAcc_q, mulCand_q, mulAccNext;
    logic [W-1:0]   mulPlier_q;
    logic [CW-1:0]  mulCnt_q;
    logic           exIsMul, mulDone;

    // Multiplier step, stall control and EX result/flag selection.
    always_comb begin
        exIsMul    = exValid_q && (exOp_q == OP_MUL);
        mulAccNext = mulAcc_q + (mulPlier_q[0] ? mulCand_q : '0);
        mulDone    = (mulCnt_q == CW'(W - 1));
        in_ready   = !(exIsMul && !mulDone);
        retire     = exValid_q && (!exIsMul || mulDone);
        exResult   = aluResult;
        exFlags    = aluFlags;
        if (exIsMul) begin
            exResult        = mulAccNext[W-1:0];
            exFlags[FLAG_Z] = (mulAccNext[W-1:0] == '0);
            exFlags[FLAG_S] = mulAccNext[W-1];
            exFlags[FLAG_C] = (mulAccNext[2*W-1:W] != '0);
            exFlags[FLAG_O] = (mulAccNext[2*W-1:W] != '0);
        end
    end

    // Shift-add state: loaded on MUL issue, one multiplier bit per EX cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mulAcc_q   <= '0;
            mulCand_q  <= '0;
            mulPlier_q <= '0;
            mulCnt_q   <= '0;
        end else if (accept && (op_e'(op) == OP_MUL)) begin
            mulAcc_q   <= '0;
            mulCand_q  <= {{W{1'b0}}, opA};
            mulPlier_q <= opB;
            mulCnt_q   <= '0;
        end else if (exIsMul && !mulDone) begin
            mulAcc_q   <= mulAccNext;
            mulCand_q  <= mulCand_q << 1;
            mulPlier_q <= mulPlier_q >> 1;
            mulCnt_q   <= mulCnt_q + CW'(1);
        end
    end
`else
    // Without the multiplier every EX instruction retires in one cycle.
    always_comb begin
        in_ready = 1'b1;
        retire   = exValid_q;
        exResult = aluResult;
        exFlags  = aluFlags;
    end
`endif

    // Issue handshake and operand read with bypass from the retiring EX result.
    always_comb begin
        accept   = in_valid && in_ready;
        exWrites = retire && op_writes(exOp_q);
        opA      = (exWrites && (exDest_q == sel_a)) ? exResult : regFile_q[sel_a];
        opB      = (exWrites && (exDest_q == sel_b)) ? exResult : regFile_q[sel_b];
    end

    // EX stage register: filled on accept, emptied when its instruction retires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exValid_q <= 1'b0;
            exOp_q    <= OP_ADD;
            exA_q     <= '0;
            exB_q     <= '0;
            exImm_q   <= '0;
            exDest_q  <= '0;
        end else if (accept) begin
            exValid_q <= 1'b1;
            exOp_q    <= op_e'(op);
            exA_q     <= opA;
            exB_q     <= opB;
            exImm_q   <= imm;
            exDest_q  <= sel_dest;
        end else if (retire) begin
            exValid_q <= 1'b0;
        end
    end

    // Register file writeback at retirement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regFile_q[i] <= '0;
        end else if (exWrites) begin
            regFile_q[exDest_q] <= exResult;
        end
    end

    // Retirement outputs and sticky flags; clr_flags wins over any update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outValid_q  <= 1'b0;
            outResult_q <= '0;
            outDest_q   <= '0;
            flags_q     <= '0;
        end else begin
            outValid_q <= retire;
            if (retire) begin
                outResult_q <= exResult;
                outDest_q   <= exDest_q;
            end
            if (clr_flags) flags_q <= '0;
            else if (retire && op_sets_flags(exOp_q)) flags_q <= exFlags;
        end
    end

    assign out_valid  = outValid_q;
    assign out_result = outResult_q;
    assign out_dest   = outDest_q;
    assign flags      = flags_q;
    assign dbg_data   = regFile_q[dbg_sel];

endmodule

// File: tb/tb_bloco_pipe.sv
// Directed testbench for bloco_pipe (BITS_PALAVRA=16, END_REGISTROS=3).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_bloco_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [2:0]  sel_dest, sel_a, sel_b;
    logic [15:0] imm;
    logic        clr_flags;
    logic        out_valid;
    logic [15:0] out_result;
    logic [2:0]  out_dest;
    logic [3:0]  flags;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_data;

    int compared   = 0;
    int mismatched = 0;

    bloco_pipe #(.BITS_PALAVRA(16), .END_REGISTROS(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .sel_dest  (sel_dest),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .imm       (imm),
        .clr_flags (clr_flags),
        .out_valid (out_valid),
        .out_result(out_result),
        .out_dest  (out_dest),
        .flags     (flags),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Wait for the falling edge, then present one instruction (or idle).
    task automatic applyStimulus(input logic v, input logic [4:0] o,
                                 input logic [2:0] d, input logic [2:0] a,
                                 input logic [2:0] b, input logic [15:0] im,
                                 input logic clr);
        @(negedge clk);
        in_valid  = v;
        op        = o;
        sel_dest  = d;
        sel_a     = a;
        sel_b     = b;
        imm       = im;
        clr_flags = clr;
    endtask

    // One comparison: count it, and report tag/observed/expected on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read a register through the debug port.
    task automatic checkReg(input string tag, input logic [2:0] r,
                            input logic [15:0] exp);
        dbg_sel = r;
        #1;
        checkOutput(tag, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    // Safety net against a stuck simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        int lowCount;
        reset_n = 1'b0; in_valid = 1'b0; op = 5'd0; sel_dest = 3'd0;
        sel_a = 3'd0; sel_b = 3'd0; imm = 16'h0; clr_flags = 1'b0; dbg_sel = 3'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Reset state
        for (int r = 0; r < 8; r++) checkReg($sformatf("reset r%0d", r), 3'(r), 16'h0);
        checkOutput("reset flags", {28'h0, flags}, 32'h0);
        checkOutput("reset out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("reset in_ready", {31'h0, in_ready}, 32'h1);

        // LDI r1, LDI r2, ADD r3=r1+r2 back to back
        applyStimulus(1, 5'd10, 3'd1, 3'd0, 3'd0, 16'h7FFF, 0);
        applyStimulus(1, 5'd10, 3'd2, 3'd0, 3'd0, 16'h0001, 0);
        checkOutput("ldi1 not yet retired", {31'h0, out_valid}, 32'h0);
        applyStimulus(1, 5'd0, 3'd3, 3'd1, 3'd2, 16'h0, 0);
        checkOutput("ldi1 valid", {31'h0, out_valid}, 32'h1);
        checkOutput("ldi1 result", {16'h0, out_result}, 32'h7FFF);
        checkOutput("ldi1 dest", {29'h0, out_dest}, 32'd1);
        checkOutput("ldi1 flags kept", {28'h0, flags}, 32'h0);
        // SUB r4=r2-r1
        applyStimulus(1, 5'd1, 3'd4, 3'd2, 3'd1, 16'h0, 0);
        checkOutput("ldi2 result", {16'h0, out_result}, 32'h0001);
        checkOutput("in_ready no stall", {31'h0, in_ready}, 32'h1);
        // CMP r2,r2
        applyStimulus(1, 5'd9, 3'd5, 3'd2, 3'd2, 16'h0, 0);
        checkOutput("add result", {16'h0, out_result}, 32'h8000);
        checkOutput("add dest", {29'h0, out_dest}, 32'd3);
        checkOutput("add flags", {28'h0, flags}, 32'b0011);
        checkReg("add r3", 3'd3, 16'h8000);
        applyStimulus(0, 5'd0, 3'd0, 3'd0, 3'd0, 16'h0, 0);
        checkOutput("sub result", {16'h0, out_result}, 32'h8002);
        checkOutput("sub flags", {28'h0, flags}, 32'b0110);
        // LDI r5=0x8001
        applyStimulus(1, 5'd10, 3'd5, 3'd0, 3'd0, 16'h8001, 0);
        checkOutput("cmp result", {16'h0, out_result}, 32'h0);
        checkOutput("cmp flags", {28'h0, flags}, 32'b1000);
        checkReg("cmp keeps r2", 3'd2, 16'h0001);
        checkReg("sub r4", 3'd4, 16'h8002);
        checkReg("cmp no write r5", 3'd5, 16'h0);
        // SHL r6=r5<<1, with clr_flags at its retire edge
        applyStimulus(1, 5'd6, 3'd6, 3'd5, 3'd0, 16'h0, 0);
        applyStimulus(0, 5'd0, 3'd0, 3'd0, 3'd0, 16'h0, 1);
        checkOutput("ldi r5 result", {16'h0, out_result}, 32'h8001);
        checkOutput("ldi keeps flags", {28'h0, flags}, 32'b1000);
        // OR r7=r3|r4
        applyStimulus(1, 5'd3, 3'd7, 3'd3, 3'd4, 16'h0, 0);
        checkOutput("shl result", {16'h0, out_result}, 32'h0002);
        checkOutput("shl clr flags", {28'h0, flags}, 32'h0);
        checkReg("shl r6", 3'd6, 16'h0002);
        // SHR r0=r5>>1
        applyStimulus(1, 5'd7, 3'd0, 3'd5, 3'd0, 16'h0, 0);
        checkOutput("bubble no valid", {31'h0, out_valid}, 32'h0);
        // Undefined op 15
        applyStimulus(1, 5'd15, 3'd1, 3'd1, 3'd1, 16'h0, 0);
        checkOutput("or result", {16'h0, out_result}, 32'h8002);
        checkOutput("or flags", {28'h0, flags}, 32'b0010);
        // ADD r7=r7+r4
        applyStimulus(1, 5'd0, 3'd7, 3'd7, 3'd4, 16'h0, 0);
        checkOutput("shr result", {16'h0, out_result}, 32'h4000);
        checkOutput("shr flags", {28'h0, flags}, 32'b0100);
`ifdef BLOCO_MULT_EN
        applyStimulus(0, 5'd0, 3'd0, 3'd0, 3'd0, 16'h0, 0);
`else
        applyStimulus(1, 5'd11, 3'd1, 3'd2, 3'd2, 16'h0, 0);
`endif
        checkOutput("undef valid", {31'h0, out_valid}, 32'h1);
        checkOutput("undef result", {16'h0, out_result}, 32'h0);
        checkOutput("undef flags kept", {28'h0, flags}, 32'b0100);
        checkReg("undef no write r1", 3'd1, 16'h7FFF);
        applyStimulus(0, 5'd0, 3'd0, 3'd0, 3'd0, 16'h0, 0);
        checkOutput("add carry result", {16'h0, out_result}, 32'h0004);
        checkOutput("add carry flags", {28'h0, flags}, 32'b0101);
        // ADD r2=r1+r1, then reset during its execute cycle
        applyStimulus(1, 5'd0, 3'd2, 3'd1, 3'd1, 16'h0, 0);
`ifdef BLOCO_MULT_EN
        checkOutput("idle no valid", {31'h0, out_valid}, 32'h0);
`else
        checkOutput("op11 undef result", {16'h0, out_result}, 32'h0);
        checkOutput("op11 undef flags", {28'h0, flags}, 32'b0101);
        checkReg("op11 no write r1", 3'd1, 16'h7FFF);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        checkOutput("midreset out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("midreset flags", {28'h0, flags}, 32'h0);
        checkOutput("midreset out_result", {16'h0, out_result}, 32'h0);
        checkReg("midreset r1", 3'd1, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("postreset out_valid", {31'h0, out_valid}, 32'h0);
        checkReg("postreset r2", 3'd2, 16'h0);

`ifdef BLOCO_MULT_EN
        // MUL r3=r1*r1 with r1 bypassed, then dependent ADD r4=r3+r1
        applyStimulus(1, 5'd10, 3'd1, 3'd0, 3'd0, 16'h0100, 0);
        applyStimulus(1, 5'd11, 3'd3, 3'd1, 3'd1, 16'h0, 0);
        applyStimulus(0, 5'd0, 3'd0, 3'd0, 3'd0, 16'h0, 0);
        lowCount = 0;
        while (!in_ready && lowCount < 100) begin
            lowCount++;
            @(negedge clk);
        end
        checkOutput("mul stall cycles", 32'(lowCount), 32'd15);
        in_valid = 1'b1; op = 5'd0; sel_dest = 3'd4; sel_a = 3'd3; sel_b = 3'd1;
        applyStimulus(0, 5'd0, 3'd0, 3'd0, 3'd0, 16'h0, 0);
        checkOutput("mul result", {16'h0, out_result}, 32'h0);
        checkOutput("mul dest", {29'h0, out_dest}, 32'd3);
        checkOutput("mul flags", {28'h0, flags}, 32'b1101);
        applyStimulus(0, 5'd0, 3'd0, 3'd0, 3'd0, 16'h0, 0);
        checkOutput("mul dep add result", {16'h0, out_result}, 32'h0100);
        checkOutput("mul dep add flags", {28'h0, flags}, 32'h0);
`else
        lowCount = 0;
        checkOutput("no-mul ready", {31'h0, in_ready}, 32'(lowCount + 1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
